// File: rtl/bus_reg_file_target.sv
// rtl/bus_reg_file_target.sv - OCP-style register-file target with access modes, hw set inputs and response queue
//
// Parametrised register file on the slave side of an OCP-style bus segment.
// Each register has an access mode (RW/RO/W1C/W1S), a bus write mask, a reset
// value and a hardware set input. Responses go through a small in-order queue,
// so commands keep being accepted while the master back-pressures responses.
//
// Command / response encodings:
//   m_cmd_i  : 0 = IDLE, 1 = WR, 2 = RD, 3 = treated as IDLE
//   s_resp_o : 0 = NULL, 1 = DVA, 2 = ERR
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   m_cmd_i          master command
//   m_addr_i         master address
//   m_data_i         master write data
//   m_resp_accept_i  master accepts the current response
//   s_cmd_accept_o   command accepted
//   s_resp_o         response code (head of response queue)
//   s_data_o         response read data
//   regs_in_i        read source for RO registers, REG_WIDTH per register
//   hw_set_i         per-bit set requests, REG_WIDTH per register
//   regs_o           current register contents, REG_WIDTH per register
//   reading_o        combinational read-accept pulse per register
//   writing_o        combinational write-accept pulse per register

module bus_reg_file_target #(
    parameter int unsigned                    NUM_REGS     = 4,
    parameter int unsigned                    ADDR_WIDTH   = 32,
    parameter int unsigned                    REG_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0]          BASE_ADDR    = '0,
    parameter logic [ADDR_WIDTH-1:0]          BASE_MASK    = '1,
    parameter logic [ADDR_WIDTH-1:0]          OFFSET_MASK  = ADDR_WIDTH'(3),
    parameter logic [2*NUM_REGS-1:0]          MODES        = '0,
    parameter logic [REG_WIDTH*NUM_REGS-1:0]  WRITE_MASK   = '1,
    parameter logic [REG_WIDTH*NUM_REGS-1:0]  RESET_VALUES = '0,
    parameter int unsigned                    RESP_DEPTH   = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [1:0]                    m_cmd_i,
    input  logic [ADDR_WIDTH-1:0]         m_addr_i,
    input  logic [REG_WIDTH-1:0]          m_data_i,
    input  logic                          m_resp_accept_i,
    output logic                          s_cmd_accept_o,
    output logic [1:0]                    s_resp_o,
    output logic [REG_WIDTH-1:0]          s_data_o,
    input  logic [REG_WIDTH*NUM_REGS-1:0] regs_in_i,
    input  logic [REG_WIDTH*NUM_REGS-1:0] hw_set_i,
    output logic [REG_WIDTH*NUM_REGS-1:0] regs_o,
    output logic [NUM_REGS-1:0]           reading_o,
    output logic [NUM_REGS-1:0]           writing_o
);

    localparam logic [1:0] CMD_WR    = 2'd1;
    localparam logic [1:0] CMD_RD    = 2'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;
    localparam logic [1:0] MODE_RW   = 2'd0;
    localparam logic [1:0] MODE_RO   = 2'd1;
    localparam logic [1:0] MODE_W1C  = 2'd2;
    localparam logic [1:0] MODE_W1S  = 2'd3;
    localparam int unsigned CNT_W    = $clog2(RESP_DEPTH + 1);

    logic [REG_WIDTH-1:0]  reg_q    [NUM_REGS];
    logic [REG_WIDTH-1:0]  reg_d    [NUM_REGS];
    // Shift-register queue: entry 0 is the head and drives the outputs directly,
    // so empty slots are kept at NULL/0.
    logic [1:0]            qresp_q  [RESP_DEPTH];
    logic [1:0]            qresp_d  [RESP_DEPTH];
    logic [REG_WIDTH-1:0]  qdata_q  [RESP_DEPTH];
    logic [REG_WIDTH-1:0]  qdata_d  [RESP_DEPTH];
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;

    logic                  is_wr;
    logic                  is_rd;
    logic                  hit;
    logic                  mapped;
    logic                  pop;
    logic                  cmd_accept;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] offset;
    logic [CNT_W-1:0]      push_idx;
    logic [1:0]            new_resp;
    logic [REG_WIDTH-1:0]  rd_data;
    logic [REG_WIDTH-1:0]  wmask;

    always_comb begin
        is_wr      = (m_cmd_i == CMD_WR);
        is_rd      = (m_cmd_i == CMD_RD);
        hit        = (is_wr || is_rd) &&
                     ((m_addr_i & BASE_MASK & ~OFFSET_MASK) == BASE_ADDR);
        offset     = m_addr_i & OFFSET_MASK;
        // Widened compare so NUM_REGS = 2^ADDR_WIDTH does not wrap to zero.
        mapped     = ({1'b0, offset} < (ADDR_WIDTH + 1)'(NUM_REGS));
        pop        = (qresp_q[0] != RESP_NULL) && m_resp_accept_i;
        cmd_accept = (count_q < CNT_W'(RESP_DEPTH)) || pop;
        accept     = hit && cmd_accept;

        rd_data    = '0;
        reading_o  = '0;
        writing_o  = '0;
        wmask      = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_d[i] = reg_q[i];
            wmask    = WRITE_MASK[REG_WIDTH*i +: REG_WIDTH];
            if (accept && mapped && (offset == ADDR_WIDTH'(i))) begin
                if (is_rd) begin
                    reading_o[i] = 1'b1;
                    rd_data = (MODES[2*i +: 2] == MODE_RO) ?
                              regs_in_i[REG_WIDTH*i +: REG_WIDTH] : reg_q[i];
                end
                if (is_wr && (MODES[2*i +: 2] != MODE_RO)) begin
                    writing_o[i] = 1'b1;
                    case (MODES[2*i +: 2])
                        MODE_RW:  reg_d[i] = (reg_q[i] & ~wmask) | (m_data_i & wmask);
                        MODE_W1C: reg_d[i] = reg_q[i] & ~(m_data_i & wmask);
                        MODE_W1S: reg_d[i] = reg_q[i] | (m_data_i & wmask);
                        default:  reg_d[i] = reg_q[i];
                    endcase
                end
            end
            // Hardware set lands after the bus update so events beat a W1C.
            if (MODES[2*i +: 2] != MODE_RO) begin
                reg_d[i] = reg_d[i] | hw_set_i[REG_WIDTH*i +: REG_WIDTH];
            end
        end

        new_resp = mapped ? RESP_DVA : RESP_ERR;
        push_idx = count_q - CNT_W'(pop);
        for (int i = 0; i < RESP_DEPTH; i++) begin
            if (pop) begin
                qresp_d[i] = (i + 1 < RESP_DEPTH) ? qresp_q[(i + 1) % RESP_DEPTH] : RESP_NULL;
                qdata_d[i] = (i + 1 < RESP_DEPTH) ? qdata_q[(i + 1) % RESP_DEPTH] : '0;
            end else begin
                qresp_d[i] = qresp_q[i];
                qdata_d[i] = qdata_q[i];
            end
            if (accept && (CNT_W'(i) == push_idx)) begin
                qresp_d[i] = new_resp;
                qdata_d[i] = rd_data;
            end
        end
        count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= RESET_VALUES[REG_WIDTH*i +: REG_WIDTH];
            end
            for (int i = 0; i < RESP_DEPTH; i++) begin
                qresp_q[i] <= RESP_NULL;
                qdata_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= reg_d[i];
            end
            for (int i = 0; i < RESP_DEPTH; i++) begin
                qresp_q[i] <= qresp_d[i];
                qdata_q[i] <= qdata_d[i];
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[REG_WIDTH*i +: REG_WIDTH] = reg_q[i];
        end
    end

    assign s_cmd_accept_o = cmd_accept;
    assign s_resp_o       = qresp_q[0];
    assign s_data_o       = qdata_q[0];

endmodule
